vga_image_reader: RTL and testbench
===================================

Name: vga_image_reader

Overview:
- Reads side of the image ROM.
- Generates 640x480 VGA scan timing and computes ROM addresses for a low-resolution stored image, upscaled by pixel replication.
- Captures the ROM's registered read data and outputs RGB with hsync/vsync/de, all aligned to the same clock.
- Sits between the pixel-clock enable generator and the DAC/VGA pins; drives the image ROM's addr input and consumes its rdata.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
IMG_W, 80, stored image width in pixels
IMG_H, 60, stored image height in pixels
SCALE_SHIFT, 3, log2 of the replication factor (8x8)
ADDR_WIDTH, 13, ROM address width; IMG_W*IMG_H <= 2^ADDR_WIDTH
DATA_WIDTH, 24, ROM word width, {R[23:16],G[15:8],B[7:0]}

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pix_en  in  1  one-clk strobe per pixel; tie high for pixel-rate clk
rom_addr  out  ADDR_WIDTH  registered ROM address
rom_rdata  in  DATA_WIDTH  ROM data, valid 1 clk after rom_addr
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
de  out  1  display enable (active video)
rgb  out  DATA_WIDTH  pixel colour, 0 when de low
frame_start  out  1  1-clk pulse aligned with output of pixel (0,0)

Behaviour:
- Reset (async, takes effect immediately, including mid-frame): h_cnt=0, v_cnt=0, rom_addr=0, hsync=1, vsync=1, de=0, rgb=0, frame_start=0, all pipeline registers cleared.
- Counters advance only on pix_en. h_cnt runs 0..H_TOTAL-1 (800). At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. v_cnt runs 0..V_TOTAL-1 (525) and wraps to 0 at the end of the last line.
- Stage 1 (registered every clk from the current counters):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs_n = !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. [656,751]
  - vs_n = !(v_cnt in [490,491])
  - fs = (h_cnt==0 && v_cnt==0)
  - rom_addr = (v_cnt>>SCALE_SHIFT)*IMG_W + (h_cnt>>SCALE_SHIFT) when active and in image bounds, else 0
  - Address is computed in ADDR_WIDTH bits and must never overflow for in-bounds pixels.
- In-bounds: (h_cnt>>SCALE_SHIFT)<IMG_W && (v_cnt>>SCALE_SHIFT)<IMG_H. Active pixels outside the image produce rgb=0 with de=1.
- Stage 2 (1 clk later, matching ROM latency):
  - rgb = rom_rdata if stage-1 active && in-bounds, else 0
  - hsync/vsync/de/frame_start are copies of the stage-1 values
- Total latency from counter value to outputs: 2 clk, fixed, independent of pix_en rate.
- With a slow pix_en (e.g. every 4 clk), outputs settle 2 clk after each counter change and then hold until the next strobe.
- frame_start is high for exactly 1 clk per frame, even when pix_en is slow, because it is edge-qualified on the counter transition into (0,0).
- Simultaneous rst and pix_en: rst wins.
- No back-pressure. The ROM is read every clk.

Test Plan:
1. Assert rst mid-line at h=300, v=100 -> all outputs at reset values immediately; after release, the first pix_en gives h=1, and rom_addr=0 two clk later.
2. pix_en tied high with a ROM model holding data=addr:
   - pixel (0,0) -> addr 0
   - (7,0) -> 0
   - (8,0) -> 1
   - (0,8) -> 80
   - (639,479) -> 4799
   - rgb equals the expected addr with de=1, 2 clk after the counter value.
3. Sync timing over one frame -> hsync low for exactly 96 pixels starting at h=656; vsync low for lines 490-491 (1600 pixel periods); de high for 640x480=307200 pixels per frame.
4. Blanking at h=640..799 -> de=0, rgb=0, rom_addr=0 regardless of rom_rdata=24'hFFFFFF.
5. pix_en every 4th clk -> same pixel sequence as scenario 2; each output holds 4 clk; frame_start pulses exactly 1 clk per frame (one pulse per 1,680,000 clk).
6. Parameter override IMG_W=40, IMG_H=30 with SCALE_SHIFT=3 -> pixel (320,0) has de=1, rgb=0, rom_addr=0; pixel (319,239) has addr 29*40+39=1199.

Source files
------------

// File: rtl/vga_image_reader.sv
// VGA scan timing generator and image-ROM reader: produces 640x480 sync/enable timing and
// fetches a low-resolution stored image, upscaled by pixel replication, with a fixed 2-clk pipeline.
module vga_image_reader #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 80,
    parameter int IMG_H       = 60,
    parameter int SCALE_SHIFT = 3,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [DATA_WIDTH-1:0] rgb,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] IMG_W_H  = HW'(IMG_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] IMG_H_V  = VW'(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_A = ADDR_WIDTH'(IMG_W);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          stepped;

    logic                  active, in_img, hs_on, vs_on;
    logic [ADDR_WIDTH-1:0] col_idx, row_idx, addr_next;

    logic act1, vis1, hs1, vs1, fs1;

    // stepped marks the clk right after a counter advance, so frame_start fires once per frame
    // even when pix_en strobes slowly and (0,0) is held for several clks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            stepped <= 1'b0;
        end else begin
            stepped <= pix_en;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        col_idx   = ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
        row_idx   = ADDR_WIDTH'(v_cnt >> SCALE_SHIFT);
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_img    = ((h_cnt >> SCALE_SHIFT) < IMG_W_H) && ((v_cnt >> SCALE_SHIFT) < IMG_H_V);
        hs_on     = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
        vs_on     = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
        addr_next = '0;
        if (active && in_img) begin
            addr_next = row_idx * IMG_W_A + col_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act1     <= 1'b0;
            vis1     <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            fs1      <= 1'b0;
            rom_addr <= '0;
        end else begin
            act1     <= active;
            vis1     <= active && in_img;
            hs1      <= !hs_on;
            vs1      <= !vs_on;
            fs1      <= (h_cnt == '0) && (v_cnt == '0) && stepped;
            rom_addr <= addr_next;
        end
    end

    // Second stage lines up with the ROM's one-clk read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else begin
            de          <= act1;
            hsync       <= hs1;
            vsync       <= vs1;
            frame_start <= fs1;
            rgb         <= vis1 ? rom_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vga_image_reader.sv
// Self-checking bench: three configurations (default, narrow image, tiny timing) driven with
// random pix_en patterns and async resets, compared against a pixel-history reference model.
module tb_vga_image_reader;

    // Instance 0: default; 1: IMG 40x30; 2: tiny timing so whole frames fit in the run.
    localparam int HA [3] = '{640, 640, 16};
    localparam int HF [3] = '{16, 16, 2};
    localparam int HS [3] = '{96, 96, 3};
    localparam int HB [3] = '{48, 48, 3};
    localparam int VA [3] = '{480, 480, 8};
    localparam int VF [3] = '{10, 10, 1};
    localparam int VS [3] = '{2, 2, 2};
    localparam int VB [3] = '{33, 33, 1};
    localparam int IW [3] = '{80, 40, 6};
    localparam int IH [3] = '{60, 30, 3};
    localparam int SH [3] = '{3, 3, 1};

    logic clk = 1'b0;
    logic rst;
    logic pixEn;

    logic [12:0] addr0, addr1;
    logic [4:0]  addr2;
    logic [23:0] rdata0, rdata1, rdata2;
    logic        hs [3];
    logic        vs [3];
    logic        de [3];
    logic        fs [3];
    logic [23:0] rgb [3];

    int checkCount = 0;
    int errorCount = 0;

    int mh [3];
    int mv [3];
    int eh [3][3];
    int ev [3][3];
    bit estep [3][3];
    bit erst [3][3];

    always #5 clk = ~clk;

    // ROM contents: word = bitwise complement of its address, so blanking (addr 0) reads all ones.
    assign rdata0 = ~24'(addr0);
    assign rdata1 = ~24'(addr1);
    assign rdata2 = ~24'(addr2);

    vga_image_reader dutFull (
        .clk(clk), .rst(rst), .pix_en(pixEn), .rom_addr(addr0), .rom_rdata(rdata0),
        .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .rgb(rgb[0]), .frame_start(fs[0])
    );

    vga_image_reader #(.IMG_W(40), .IMG_H(30)) dutNarrow (
        .clk(clk), .rst(rst), .pix_en(pixEn), .rom_addr(addr1), .rom_rdata(rdata1),
        .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .rgb(rgb[1]), .frame_start(fs[1])
    );

    vga_image_reader #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .IMG_W(6), .IMG_H(3), .SCALE_SHIFT(1), .ADDR_WIDTH(5)
    ) dutTiny (
        .clk(clk), .rst(rst), .pix_en(pixEn), .rom_addr(addr2), .rom_rdata(rdata2),
        .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .rgb(rgb[2]), .frame_start(fs[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit visOf(input int i, input int h, input int v);
        return (h < HA[i]) && (v < VA[i]) && ((h >> SH[i]) < IW[i]) && ((v >> SH[i]) < IH[i]);
    endfunction

    function automatic int addrOf(input int i, input int h, input int v);
        return visOf(i, h, v) ? (v >> SH[i]) * IW[i] + (h >> SH[i]) : 0;
    endfunction

    function automatic logic [31:0] obsAddr(input int i);
        case (i)
            0:       return 32'(addr0);
            1:       return 32'(addr1);
            default: return 32'(addr2);
        endcase
    endfunction

    task automatic markReset();
        for (int i = 0; i < 3; i++) begin
            mh[i] = 0;
            mv[i] = 0;
            for (int a = 0; a < 3; a++) begin
                eh[i][a] = 0; ev[i][a] = 0; estep[i][a] = 1'b0; erst[i][a] = 1'b1;
            end
        end
    endtask

    // Advance the model by one clk edge given the inputs seen at that edge.
    task automatic updateModel(input bit r, input bit p);
        for (int i = 0; i < 3; i++) begin
            for (int a = 2; a > 0; a--) begin
                eh[i][a] = eh[i][a-1]; ev[i][a] = ev[i][a-1];
                estep[i][a] = estep[i][a-1]; erst[i][a] = erst[i][a-1];
            end
            if (r) begin
                mh[i] = 0;
                mv[i] = 0;
            end else if (p) begin
                mh[i]++;
                if (mh[i] == HA[i] + HF[i] + HS[i] + HB[i]) begin
                    mh[i] = 0;
                    mv[i]++;
                    if (mv[i] == VA[i] + VF[i] + VS[i] + VB[i]) mv[i] = 0;
                end
            end
            eh[i][0] = mh[i]; ev[i][0] = mv[i];
            estep[i][0] = !r && p; erst[i][0] = r;
        end
    endtask

    task automatic checkResetNow();
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_addr", obsAddr(i), 32'd0);
            checkOutput("rst_hsync", 32'(hs[i]), 32'd1);
            checkOutput("rst_vsync", 32'(vs[i]), 32'd1);
            checkOutput("rst_de", 32'(de[i]), 32'd0);
            checkOutput("rst_rgb", 32'(rgb[i]), 32'd0);
            checkOutput("rst_fs", 32'(fs[i]), 32'd0);
        end
    endtask

    task automatic checkAll();
        int h, v;
        bit eHs, eVs, eDe, eFs;
        logic [23:0] eRgb;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rom_addr", obsAddr(i), erst[i][0] ? 32'd0 : 32'(addrOf(i, eh[i][1], ev[i][1])));
            h = eh[i][2];
            v = ev[i][2];
            if (erst[i][0] || erst[i][1]) begin
                eHs = 1'b1; eVs = 1'b1; eDe = 1'b0; eFs = 1'b0; eRgb = '0;
            end else begin
                eDe  = (h < HA[i]) && (v < VA[i]);
                eHs  = !((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]));
                eVs  = !((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]));
                eFs  = (h == 0) && (v == 0) && estep[i][2];
                eRgb = visOf(i, h, v) ? ~24'(addrOf(i, h, v)) : 24'd0;
            end
            checkOutput("hsync", 32'(hs[i]), 32'(eHs));
            checkOutput("vsync", 32'(vs[i]), 32'(eVs));
            checkOutput("de", 32'(de[i]), 32'(eDe));
            checkOutput("frame_start", 32'(fs[i]), 32'(eFs));
            checkOutput("rgb", 32'(rgb[i]), 32'(eRgb));
        end
    endtask

    // mode 0: pix_en high; 1: every 4th clk; 2: random. rstAt < 0 means no reset in this phase.
    task automatic applyStimulus(input int mode, input int cycles, input int rstAt);
        for (int c = 0; c < cycles; c++) begin
            case (mode)
                0:       pixEn = 1'b1;
                1:       pixEn = (c % 4 == 0);
                default: pixEn = 1'($urandom_range(0, 1));
            endcase
            if (c == rstAt + 3) rst = 1'b0;
            if (c == rstAt) begin
                #2 rst = 1'b1;
                markReset();
                #1 checkResetNow();
            end
            @(posedge clk);
            updateModel(rst, pixEn);
            @(negedge clk);
            checkAll();
        end
    endtask

    initial begin
        rst   = 1'b1;
        pixEn = 1'b0;
        markReset();
        repeat (3) begin
            @(posedge clk);
            updateModel(1'b1, 1'b0);
        end
        @(negedge clk);
        checkAll();
        rst = 1'b0;
        $display("[TB] phase: pix_en high with mid-line reset");
        applyStimulus(0, 10000, int'($urandom_range(1500, 2500)));
        $display("[TB] phase: pix_en every 4th clk");
        applyStimulus(1, 4000, -1);
        $display("[TB] phase: random pix_en with reset");
        applyStimulus(2, 10000, int'($urandom_range(3000, 6000)));
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
